// File: rtl/u_multu.sv
// Iterative 32-cycle shift-add unsigned multiplier for multu/mfhi/mflo in EX.
// Produces HI/LO and stalls dependent instructions while a multiply is in flight.
module u_multu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_u_multu_clk,
  input  logic             i_u_multu_rst,
  input  logic             i_u_multu_mult_en,
  input  logic [1:0]       i_u_multu_mf,
  input  logic [WIDTH-1:0] i_u_multu_rs,
  input  logic [WIDTH-1:0] i_u_multu_rt,
  output logic             o_u_multu_busy,
  output logic             o_u_multu_stall,
  output logic [WIDTH-1:0] o_u_multu_hi,
  output logic [WIDTH-1:0] o_u_multu_lo,
  output logic [WIDTH-1:0] o_u_multu_mf_data
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic [PROD_W-1:0]   p_q;
  logic [PROD_W-1:0]   p_d;
  logic [WIDTH:0]      sum_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_iter;

  // One shift-add step: add multiplicand to the upper half when P[0] is set, keep carry.
  always_comb begin
    sum_d     = {1'b0, p_q[PROD_W-1:WIDTH]} + {1'b0, (p_q[0] ? mcand_q : WIDTH'(0))};
    p_d       = {sum_d, p_q[WIDTH-1:1]};
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge i_u_multu_clk) begin
    if (i_u_multu_rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_u_multu_mult_en) begin
            mcand_q <= i_u_multu_rs;
            p_q     <= {WIDTH'(0), i_u_multu_rt};
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= p_d[PROD_W-1:WIDTH];
            lo_q    <= p_d[WIDTH-1:0];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_u_multu_busy  = (state_q == RUN);
  assign o_u_multu_hi    = hi_q;
  assign o_u_multu_lo    = lo_q;
  assign o_u_multu_stall = o_u_multu_busy &
                           (i_u_multu_mult_en | (i_u_multu_mf == 2'b01) | (i_u_multu_mf == 2'b10));

  // Move-from mux shows committed HI/LO only; a stalled reader sees stale data.
  always_comb begin
    o_u_multu_mf_data = '0;
    case (i_u_multu_mf)
      2'b01:   o_u_multu_mf_data = hi_q;
      2'b10:   o_u_multu_mf_data = lo_q;
      default: o_u_multu_mf_data = '0;
    endcase
  end

endmodule

// File: tb/tb_u_multu.sv
// Bench for u_multu: directed and random multiplies checked against a 64-bit
// arithmetic reference of HI/LO, plus stall and busy-length checks.
module tb_u_multu;

  logic        clk;
  logic        rst;
  logic        mult_en;
  logic [1:0]  mf;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int unsigned n_chk;
  int unsigned n_fail;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  u_multu #(.WIDTH(32)) dut (
    .i_u_multu_clk     (clk),
    .i_u_multu_rst     (rst),
    .i_u_multu_mult_en (mult_en),
    .i_u_multu_mf      (mf),
    .i_u_multu_rs      (rs),
    .i_u_multu_rt      (rt),
    .o_u_multu_busy    (busy),
    .o_u_multu_stall   (stall),
    .o_u_multu_hi      (hi),
    .o_u_multu_lo      (lo),
    .o_u_multu_mf_data (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_mult(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    hi_m = prod[63:32];
    lo_m = prod[31:0];
  endtask

  // Issue one multiply, optionally holding mf while busy, and check length/stall/result.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mf_hold);
    int n;
    int n_stall;
    rs = a; rt = b; mf = 2'b00; mult_en = 1'b1;
    tick();
    mult_en = 1'b0; mf = mf_hold; rs = $urandom; rt = $urandom;
    #1;
    n = 0; n_stall = 0;
    while (busy && n < 40) begin
      check("hi_stable_busy", 64'(hi), 64'(hi_m));
      if (stall) n_stall++;
      n++;
      tick();
    end
    check("busy_cycles", 64'(n), 64'd32);
    check("stall_cycles", 64'(n_stall), (mf_hold == 2'b01 || mf_hold == 2'b10) ? 64'd32 : 64'd0);
    model_mult(a, b);
    check("hi", 64'(hi), 64'(hi_m));
    check("lo", 64'(lo), 64'(lo_m));
    check("stall_after", 64'(stall), 64'd0);
    mf = 2'b00;
    #1;
  endtask

  task automatic check_reads();
    mf = 2'b01; #1; check("mfhi", 64'(mf_data), 64'(hi_m));
    mf = 2'b10; #1; check("mflo", 64'(mf_data), 64'(lo_m));
    mf = 2'b11; #1; check("mf_rsvd", 64'(mf_data), 64'd0);
    mf = 2'b00; #1; check("mf_none", 64'(mf_data), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    hi_m = '0; lo_m = '0;
    rst = 1'b1; mult_en = 1'b0; mf = 2'b00; rs = '0; rt = '0;
    tick(); tick();
    rst = 1'b0; mf = 2'b01;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mf_data", 64'(mf_data), 64'd0);
    mf = 2'b00;

    do_mult(32'd3, 32'd5, 2'b00);
    check("basic_lo", 64'(lo), 64'h0000000F);
    check_reads();

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    check("max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("max_lo", 64'(lo), 64'h0000_0001);
    do_mult(32'h8000_0000, 32'd2, 2'b00);
    check("msb_hi", 64'(hi), 64'h0000_0001);
    check_reads();

    do_mult(32'd7, 32'd6, 2'b01);
    mf = 2'b01; #1;
    check("rd_hi_first", 64'(mf_data), 64'h0);
    mf = 2'b10; #1;
    check("rd_lo", 64'(mf_data), 64'h2A);
    mf = 2'b00;

    // Reserved mf during a multiply neither stalls nor returns data.
    do_mult(32'h0001_0001, 32'h0000_FFFF, 2'b11);
    check_reads();

    // Simultaneous mult_en and mf in IDLE: multiply starts, read sees old HI.
    rs = 32'd10; rt = 32'd10; mult_en = 1'b1; mf = 2'b01; #1;
    check("sim_mf_old", 64'(mf_data), 64'(hi_m));
    check("sim_stall", 64'(stall), 64'd0);
    tick();
    mult_en = 1'b0; mf = 2'b00;
    for (int i = 0; i < 40 && busy; i++) tick();
    model_mult(32'd10, 32'd10);
    check("sim_lo", 64'(lo), 64'd100);

    // Back-to-back: second multiply held by stall and accepted right after busy falls.
    rs = 32'd2; rt = 32'd3; mult_en = 1'b1;
    tick();
    rs = 32'd4; rt = 32'd4;
    #1;
    begin
      int n;
      int n_stall;
      n = 0; n_stall = 0;
      while (busy && n < 40) begin
        if (stall) n_stall++;
        n++;
        tick();
      end
      check("b2b_stall", 64'(n_stall), 64'd32);
    end
    check("b2b_gap_busy", 64'(busy), 64'd0);
    check("b2b_gap_lo", 64'(lo), 64'd6);
    check("b2b_gap_stall", 64'(stall), 64'd0);
    tick();
    mult_en = 1'b0;
    #1;
    check("b2b_second_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 40 && busy; i++) tick();
    check("b2b_lo", 64'(lo), 64'h10);
    check("b2b_hi", 64'(hi), 64'h0);
    model_mult(32'd4, 32'd4);

    // Reset mid-operation aborts without writing a partial product.
    do_mult(32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00);
    rs = 32'h1234_5678; rt = 32'h1234_5678; mult_en = 1'b1;
    tick();
    mult_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; hi_m = '0; lo_m = '0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    tick(); tick();
    check("mid_rst_hold_lo", 64'(lo), 64'd0);
    do_mult(32'd1, 32'd9, 2'b00);
    check("after_rst_lo", 64'(lo), 64'd9);

    for (int k = 0; k < 8; k++) begin
      do_mult($urandom, $urandom, 2'($urandom_range(0, 3)));
      check_reads();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/u_multu.md
# u_multu

Iterative unsigned multiply unit for the MIPS pipeline, serving the `multu`, `mfhi` and `mflo` instructions. It sits in the EX stage. It consumes the control unit's multiply-enable and move-from select (`mult_en`, `mf`) together with the forwarded rs/rt operands. It computes the 64-bit product in HI/LO over 32 cycles and raises a pipeline stall while a dependent instruction would otherwise read or restart it.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- i_u_multu_clk  input  1  clock; everything is sampled on the rising edge.
- i_u_multu_rst  input  1  reset, synchronous, active-high.
- i_u_multu_mult_en  input  1  a `multu` is in EX this cycle (from the control unit's mult_en).
- i_u_multu_mf  input  2  move-from select: 2'b00 none, 2'b01 mfhi, 2'b10 mflo, 2'b11 reserved.
- i_u_multu_rs  input  WIDTH  multiplicand (rs, after forwarding).
- i_u_multu_rt  input  WIDTH  multiplier (rt, after forwarding).
- o_u_multu_busy  output  1  a multiply is in progress.
- o_u_multu_stall  output  1  hold IF/ID/EX this cycle.
- o_u_multu_hi  output  WIDTH  HI register.
- o_u_multu_lo  output  WIDTH  LO register.
- o_u_multu_mf_data  output  WIDTH  move-from result for the EX write-back mux.

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- **IDLE, mult_en=1:**
  - Latch rs into the multiplicand register (WIDTH bits).
  - Load the product register P[2*WIDTH-1:0] = {WIDTH'b0, rt}.
  - Clear the iteration counter cnt (5 bits for WIDTH=32) and go to RUN.
  - HI/LO are unchanged at this point.
- **IDLE, mult_en=0:** hold all state.
- **RUN, each cycle (shift-add):**
  - sum[WIDTH:0] = P[2*WIDTH-1:WIDTH] + (P[0] ? mcand : 0); this is a WIDTH+1-bit add with the carry kept.
  - P <= {sum, P[WIDTH-1:1]}, i.e. a right shift by one with the carry entering the MSB.
  - cnt <= cnt+1.
- **RUN, cnt == WIDTH-1:**
  - The final iteration also writes HI <= next P[2*WIDTH-1:WIDTH] and LO <= next P[WIDTH-1:0].
  - FSM returns to IDLE.
- mult_en while in RUN is ignored by the datapath. The stall keeps the instruction in EX, so it is accepted on the first IDLE cycle.
- busy = (state == RUN).
- stall = busy & (mult_en | mf==2'b01 | mf==2'b10). Combinational, with no dependence on the clock edge.
- mf_data is combinational:
  - HI when mf=2'b01.
  - LO when mf=2'b10.
  - 0 when mf is 2'b00 or 2'b11.
  - While stalled, mf_data still shows the old HI/LO. Downstream must not commit it because stall is high.
- mf=2'b11 never stalls and returns 0.
- Arithmetic is unsigned only. There is no overflow; the full 2*WIDTH-bit product is always exact.

## Timing
- **Reset values (on the rising edge with rst=1):**
  - state IDLE; P, mcand and cnt are 0.
  - HI and LO are 0.
  - busy=0 and stall=0 (with mult_en=0).
- **Reset priority:**
  - Reset has priority over every other input.
  - A reset asserted during RUN aborts the multiply: HI/LO go to 0 and are not written with a partial product.
- **Latency:**
  - The issue edge E0 samples mult_en=1 in IDLE.
  - busy is high from after E0 through the cycle before E32.
  - HI/LO take the product at edge E32, and busy falls at E32.
  - busy is high for exactly WIDTH cycles.
- **Earliest next issue:** a `multu` presented in the cycle after E32 is accepted at E33. There is no forced idle cycle beyond IDLE itself.
- **mfhi/mflo following a multu:**
  - stall is high in every cycle between E0 and E32.
  - In the cycle after E32, mf_data equals the new product half and stall=0.
- **Simultaneous mult_en and mf:** cannot occur from a legal decode. If both are high in IDLE, the multiply starts, and mf_data returns the pre-multiply HI/LO for that cycle.
- **Reads of HI/LO:** these are registered outputs and change only at E32 or on reset.

## Test plan
- **Reset:** rst=1 for 2 cycles, then mf=2'b01 -> hi=lo=0, busy=0, stall=0, mf_data=0.
- **Basic multiply:** rs=3, rt=5, mult_en pulse -> busy=1 for exactly 32 cycles; then hi=0x00000000, lo=0x0000000F; mflo mf_data=0x0000000F.
- **Maximum operands:** rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then rs=0x80000000, rt=2 -> hi=0x00000001, lo=0x00000000.
- **Stall on read:**
  - Issue rs=7, rt=6, then hold mf=2'b01 from the next cycle -> stall=1 for 32 cycles.
  - The first non-stalled cycle shows mf_data=0x00000000 (HI).
  - Then mf=2'b10 gives 0x0000002A.
- **Back-to-back:**
  - Issue rs=2, rt=3 and keep mult_en high with rs=4, rt=4 -> stall=1 during the first multiply.
  - The second starts the cycle after busy falls; the final lo=0x00000010.
  - lo=0x00000006 is visible for one cycle between the two multiplies.
- **Reset mid-operation:** issue rs=rt=0x12345678, assert rst at iteration 10 -> state IDLE, busy=0, hi=lo=0. A subsequent rs=1, rt=9 yields lo=9.
